// File: rtl/rs_param_station.sv
// rs_param_station: N-way reservation station between dispatch and FU issue.
// Fills the lowest free entries, snoops the CDB and issues into registered lanes.
module rs_param_station #(
  parameter int RS_DEPTH  = 16,
  parameter int DP_WIDTH  = 3,
  parameter int IS_WIDTH  = 3,
  parameter int CDB_WIDTH = 3,
  parameter int TAG_W     = 5,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64,
  localparam int CNT_W = $clog2(RS_DEPTH+1),
  localparam int FS_W  = $clog2(DP_WIDTH+1),
  localparam int IW    = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [DP_WIDTH-1:0]           dp_valid,
  input  logic [DP_WIDTH*TAG_W-1:0]     dp_tag,
  input  logic [DP_WIDTH-1:0]           dp_src1_rdy,
  input  logic [DP_WIDTH*TAG_W-1:0]     dp_src1_tag,
  input  logic [DP_WIDTH*XLEN-1:0]      dp_src1_val,
  input  logic [DP_WIDTH-1:0]           dp_src2_rdy,
  input  logic [DP_WIDTH*TAG_W-1:0]     dp_src2_tag,
  input  logic [DP_WIDTH*XLEN-1:0]      dp_src2_val,
  input  logic [DP_WIDTH*PAYLOAD_W-1:0] dp_payload,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_WIDTH*XLEN-1:0]     cdb_value,
  input  logic [IS_WIDTH-1:0]           is_ready,
  output logic [IS_WIDTH-1:0]           is_valid,
  output logic [IS_WIDTH*TAG_W-1:0]     is_tag,
  output logic [IS_WIDTH*XLEN-1:0]      is_src1_val,
  output logic [IS_WIDTH*XLEN-1:0]      is_src2_val,
  output logic [IS_WIDTH*PAYLOAD_W-1:0] is_payload,
  output logic [CNT_W-1:0]              free_cnt,
  output logic [FS_W-1:0]               dp_free_slots,
  output logic                          dp_overflow
);

  logic [RS_DEPTH-1:0]  busy_q, busy_d;
  logic [RS_DEPTH-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic [TAG_W-1:0]     t1_q [RS_DEPTH];
  logic [TAG_W-1:0]     t1_d [RS_DEPTH];
  logic [TAG_W-1:0]     t2_q [RS_DEPTH];
  logic [TAG_W-1:0]     t2_d [RS_DEPTH];
  logic [TAG_W-1:0]     tg_q [RS_DEPTH];
  logic [TAG_W-1:0]     tg_d [RS_DEPTH];
  logic [XLEN-1:0]      v1_q [RS_DEPTH];
  logic [XLEN-1:0]      v1_d [RS_DEPTH];
  logic [XLEN-1:0]      v2_q [RS_DEPTH];
  logic [XLEN-1:0]      v2_d [RS_DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [RS_DEPTH];
  logic [PAYLOAD_W-1:0] pl_d [RS_DEPTH];

  logic [IS_WIDTH-1:0]  iv_q;
  logic [TAG_W-1:0]     itag_q [IS_WIDTH];
  logic [XLEN-1:0]      is1_q  [IS_WIDTH];
  logic [XLEN-1:0]      is2_q  [IS_WIDTH];
  logic [PAYLOAD_W-1:0] ipl_q  [IS_WIDTH];

  logic [CNT_W-1:0]     fc_q, fc_d;
  logic                 ovf_q, ovf_d;

  logic [RS_DEPTH-1:0]  avail, elig;
  logic                 found;
  logic [IW-1:0]        idx;
  logic [XLEN:0]        h1, h2;
  logic [IS_WIDTH-1:0]  sel_ok;
  logic [IW-1:0]        sel_idx [IS_WIDTH];

  // {hit, value}; the lowest matching CDB lane wins
  function automatic logic [XLEN:0] cdb_hit(
    input logic [TAG_W-1:0]           t,
    input logic [CDB_WIDTH-1:0]       cv,
    input logic [CDB_WIDTH*TAG_W-1:0] ct,
    input logic [CDB_WIDTH*XLEN-1:0]  cval
  );
    logic [XLEN:0] r;
    r = '0;
    for (int j = CDB_WIDTH-1; j >= 0; j--) begin
      if (cv[j] && ct[j*TAG_W +: TAG_W] == t) begin
        r = {1'b1, cval[j*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  always_comb begin
    busy_d = busy_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    t1_d   = t1_q;
    t2_d   = t2_q;
    tg_d   = tg_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    pl_d   = pl_q;
    ovf_d  = 1'b0;
    avail  = ~busy_q;
    elig   = busy_q & r1_q & r2_q;
    found  = 1'b0;
    idx    = '0;
    h1     = '0;
    h2     = '0;
    sel_ok = '0;
    for (int l = 0; l < IS_WIDTH; l++) sel_idx[l] = '0;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (busy_q[i] && !r1_q[i]) begin
        h1 = cdb_hit(t1_q[i], cdb_valid, cdb_tag, cdb_value);
        if (h1[XLEN]) begin
          r1_d[i] = 1'b1;
          v1_d[i] = h1[XLEN-1:0];
        end
      end
      if (busy_q[i] && !r2_q[i]) begin
        h2 = cdb_hit(t2_q[i], cdb_valid, cdb_tag, cdb_value);
        if (h2[XLEN]) begin
          r2_d[i] = 1'b1;
          v2_d[i] = h2[XLEN-1:0];
        end
      end
    end

    // chained select: each open lane takes the next eligible entry
    for (int l = 0; l < IS_WIDTH; l++) begin
      if (!iv_q[l] || is_ready[l]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!sel_ok[l] && elig[i]) begin
            sel_ok[l]  = 1'b1;
            sel_idx[l] = IW'(i);
            elig[i]    = 1'b0;
          end
        end
        if (sel_ok[l]) busy_d[sel_idx[l]] = 1'b0;
      end
    end

    for (int k = 0; k < DP_WIDTH; k++) begin
      if (dp_valid[k]) begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!found && avail[i]) begin
            found = 1'b1;
            idx   = IW'(i);
          end
        end
        if (!found) begin
          ovf_d = 1'b1;
        end else begin
          h1 = cdb_hit(dp_src1_tag[k*TAG_W +: TAG_W],
                       cdb_valid, cdb_tag, cdb_value);
          h2 = cdb_hit(dp_src2_tag[k*TAG_W +: TAG_W],
                       cdb_valid, cdb_tag, cdb_value);
          avail[idx]  = 1'b0;
          busy_d[idx] = 1'b1;
          tg_d[idx]   = dp_tag[k*TAG_W +: TAG_W];
          pl_d[idx]   = dp_payload[k*PAYLOAD_W +: PAYLOAD_W];
          t1_d[idx]   = dp_src1_tag[k*TAG_W +: TAG_W];
          t2_d[idx]   = dp_src2_tag[k*TAG_W +: TAG_W];
          r1_d[idx]   = dp_src1_rdy[k] | h1[XLEN];
          r2_d[idx]   = dp_src2_rdy[k] | h2[XLEN];
          v1_d[idx]   = dp_src1_rdy[k] ? dp_src1_val[k*XLEN +: XLEN]
                                       : h1[XLEN-1:0];
          v2_d[idx]   = dp_src2_rdy[k] ? dp_src2_val[k*XLEN +: XLEN]
                                       : h2[XLEN-1:0];
        end
      end
    end

    if (squash) begin
      busy_d = '0;
      ovf_d  = 1'b0;
    end

    fc_d = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      fc_d = fc_d + CNT_W'(!busy_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      fc_q   <= CNT_W'(RS_DEPTH);
      ovf_q  <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        t1_q[i] <= '0;
        t2_q[i] <= '0;
        tg_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        pl_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      fc_q   <= fc_d;
      ovf_q  <= ovf_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      tg_q   <= tg_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      pl_q   <= pl_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iv_q <= '0;
      for (int l = 0; l < IS_WIDTH; l++) begin
        itag_q[l] <= '0;
        is1_q[l]  <= '0;
        is2_q[l]  <= '0;
        ipl_q[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < IS_WIDTH; l++) begin
        if (squash) begin
          iv_q[l] <= 1'b0;
        end else if (!iv_q[l] || is_ready[l]) begin
          iv_q[l] <= sel_ok[l];
          if (sel_ok[l]) begin
            itag_q[l] <= tg_q[sel_idx[l]];
            is1_q[l]  <= v1_q[sel_idx[l]];
            is2_q[l]  <= v2_q[sel_idx[l]];
            ipl_q[l]  <= pl_q[sel_idx[l]];
          end
        end
      end
    end
  end

  always_comb begin
    is_valid    = iv_q;
    is_tag      = '0;
    is_src1_val = '0;
    is_src2_val = '0;
    is_payload  = '0;
    for (int l = 0; l < IS_WIDTH; l++) begin
      is_tag[l*TAG_W +: TAG_W]          = itag_q[l];
      is_src1_val[l*XLEN +: XLEN]       = is1_q[l];
      is_src2_val[l*XLEN +: XLEN]       = is2_q[l];
      is_payload[l*PAYLOAD_W +: PAYLOAD_W] = ipl_q[l];
    end
  end

  assign free_cnt      = fc_q;
  assign dp_overflow   = ovf_q;
  assign dp_free_slots = (fc_q > CNT_W'(DP_WIDTH)) ? FS_W'(DP_WIDTH)
                                                   : FS_W'(fc_q);

endmodule

// File: tb/tb_rs_param_station.sv
// tb_rs_param_station: directed vector table plus a mid-run reset sequence
// for the 16-entry, 3-wide reservation station.
module tb_rs_param_station;

  logic         clock;
  logic         reset;
  logic         squash;
  logic [2:0]   dp_valid;
  logic [14:0]  dp_tag;
  logic [2:0]   dp_src1_rdy;
  logic [14:0]  dp_src1_tag;
  logic [95:0]  dp_src1_val;
  logic [2:0]   dp_src2_rdy;
  logic [14:0]  dp_src2_tag;
  logic [95:0]  dp_src2_val;
  logic [191:0] dp_payload;
  logic [2:0]   cdb_valid;
  logic [14:0]  cdb_tag;
  logic [95:0]  cdb_value;
  logic [2:0]   is_ready;
  logic [2:0]   is_valid;
  logic [14:0]  is_tag;
  logic [95:0]  is_src1_val;
  logic [95:0]  is_src2_val;
  logic [191:0] is_payload;
  logic [4:0]   free_cnt;
  logic [1:0]   dp_free_slots;
  logic         dp_overflow;

  rs_param_station dut (
    .clock(clock), .reset(reset), .squash(squash),
    .dp_valid(dp_valid), .dp_tag(dp_tag),
    .dp_src1_rdy(dp_src1_rdy), .dp_src1_tag(dp_src1_tag),
    .dp_src1_val(dp_src1_val),
    .dp_src2_rdy(dp_src2_rdy), .dp_src2_tag(dp_src2_tag),
    .dp_src2_val(dp_src2_val),
    .dp_payload(dp_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .is_ready(is_ready), .is_valid(is_valid), .is_tag(is_tag),
    .is_src1_val(is_src1_val), .is_src2_val(is_src2_val),
    .is_payload(is_payload), .free_cnt(free_cnt),
    .dp_free_slots(dp_free_slots), .dp_overflow(dp_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sq;
    logic [2:0]  dv;
    logic [14:0] dt;
    logic [2:0]  r1;
    logic [14:0] t1;
    logic [2:0]  r2;
    logic [14:0] t2;
    logic [2:0]  cv;
    logic [14:0] ct;
    logic [95:0] cval;
    logic [2:0]  ir;
    logic [2:0]  eiv;
    logic [14:0] etag;
    logic [4:0]  efc;
    logic        eovf;
    logic        ck;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [14:0] T(int a, int b, int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic vec_t mk(
    logic sq, logic [2:0] dv, logic [14:0] dt,
    logic [2:0] r1, logic [14:0] t1, logic [2:0] r2, logic [14:0] t2,
    logic [2:0] cv, logic [14:0] ct, logic [95:0] cval, logic [2:0] ir,
    logic [2:0] eiv, logic [14:0] etag, logic [4:0] efc, logic eovf,
    logic ck, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.sq = sq; v.dv = dv; v.dt = dt; v.r1 = r1; v.t1 = t1;
    v.r2 = r2; v.t2 = t2; v.cv = cv; v.ct = ct; v.cval = cval;
    v.ir = ir; v.eiv = eiv; v.etag = etag; v.efc = efc;
    v.eovf = eovf; v.ck = ck; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  function automatic vec_t idle(logic [2:0] ir, logic [2:0] eiv,
    logic [14:0] etag, logic [4:0] efc, logic eovf,
    logic ck, logic [31:0] e1, logic [31:0] e2);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir,
              eiv, etag, efc, eovf, ck, e1, e2);
  endfunction

  task automatic drive(input vec_t v);
    squash      = v.sq;
    dp_valid    = v.dv;
    dp_tag      = v.dt;
    dp_src1_rdy = v.r1;
    dp_src1_tag = v.t1;
    dp_src2_rdy = v.r2;
    dp_src2_tag = v.t2;
    for (int k = 0; k < 3; k++) begin
      dp_src1_val[k*32 +: 32] = 32'hA000_0000 | 32'(v.dt[k*5 +: 5]);
      dp_src2_val[k*32 +: 32] = 32'hB000_0000 | 32'(v.dt[k*5 +: 5]);
      dp_payload[k*64 +: 64] =
        {32'hC0DE_0000 | 32'(v.dt[k*5 +: 5]), 32'h1234_5678};
    end
    cdb_valid = v.cv;
    cdb_tag   = v.ct;
    cdb_value = v.cval;
    is_ready  = v.ir;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic chk_idle_state(input string nm);
    chk({nm, " is_valid"}, 64'(is_valid), 64'(3'b000));
    chk({nm, " free_cnt"}, 64'(free_cnt), 64'd16);
    chk({nm, " dp_free_slots"}, 64'(dp_free_slots), 64'd3);
    chk({nm, " dp_overflow"}, 64'(dp_overflow), 64'd0);
  endtask

  localparam logic [95:0] CV_DEAD = {32'h0, 32'h0000_DEAD, 32'h0};
  localparam logic [95:0] CV_55   = {32'h66, 32'h0, 32'h55};
  localparam logic [95:0] CV_77   = {64'h0, 32'h77};

  initial begin
    vec_t  v;
    string nm;
    logic [4:0] es;

    drive(idle(3'b111, 0, 0, 16, 0, 0, 0, 0));
    reset = 1'b0;
    #12;
    chk_idle_state("reset");
    reset = 1'b1;

    // dispatch 4,5,6 ready -> issue all three next cycle
    vt.push_back(mk(0, 3'b111, T(4,5,6), 3'b111, 0, 3'b111, 0, 0, 0, 0,
      3'b111, 3'b000, 0, 13, 0, 0, 0, 0));
    vt.push_back(idle(3'b111, 3'b111, T(4,5,6), 16, 0, 1,
      32'hA000_0004, 32'hB000_0004));
    vt.push_back(idle(3'b111, 3'b000, 0, 16, 0, 0, 0, 0));
    // src1 waits on tag 2, woken by cdb lane1
    vt.push_back(mk(0, 3'b001, T(7,0,0), 3'b000, T(2,0,0), 3'b111, 0,
      0, 0, 0, 3'b111, 3'b000, 0, 15, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b010, T(0,2,0), CV_DEAD,
      3'b111, 3'b000, 0, 15, 0, 0, 0, 0));
    vt.push_back(idle(3'b111, 3'b001, T(7,0,0), 16, 0, 1,
      32'h0000_DEAD, 32'hB000_0007));
    vt.push_back(idle(3'b111, 3'b000, 0, 16, 0, 0, 0, 0));
    // dispatch bypass; tag 9 on lanes 0 and 2, lane0 wins
    vt.push_back(mk(0, 3'b001, T(8,0,0), 3'b111, 0, 3'b000, T(9,0,0),
      3'b101, T(9,0,9), CV_55, 3'b111, 3'b000, 0, 15, 0, 0, 0, 0));
    vt.push_back(idle(3'b111, 3'b001, T(8,0,0), 16, 0, 1,
      32'hA000_0008, 32'h0000_0055));
    vt.push_back(idle(3'b111, 3'b000, 0, 16, 0, 0, 0, 0));
    // five ready entries, lane0 stalled
    vt.push_back(mk(0, 3'b111, T(10,11,12), 3'b111, 0, 3'b111, 0,
      0, 0, 0, 3'b110, 3'b000, 0, 13, 0, 0, 0, 0));
    vt.push_back(mk(0, 3'b011, T(13,14,0), 3'b111, 0, 3'b111, 0,
      0, 0, 0, 3'b110, 3'b111, T(10,11,12), 14, 0, 1,
      32'hA000_000A, 32'hB000_000A));
    vt.push_back(idle(3'b110, 3'b111, T(10,13,14), 16, 0, 1,
      32'hA000_000A, 32'hB000_000A));
    vt.push_back(idle(3'b110, 3'b001, T(10,0,0), 16, 0, 1,
      32'hA000_000A, 32'hB000_000A));
    vt.push_back(idle(3'b111, 3'b000, 0, 16, 0, 0, 0, 0));
    // fill all 16 entries with sources waiting on tag 31
    for (int n = 0; n < 5; n++) begin
      vt.push_back(mk(0, 3'b111, T(1,2,3), 3'b000, T(31,31,31),
        3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 0, 5'(13 - 3*n),
        0, 0, 0, 0));
    end
    vt.push_back(mk(0, 3'b011, T(1,2,3), 3'b000, T(31,31,31), 3'b111, 0,
      0, 0, 0, 3'b111, 3'b000, 0, 0, 1, 0, 0, 0));
    vt.push_back(idle(3'b111, 3'b000, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 3'b100, T(1,2,3), 3'b000, T(31,31,31), 3'b111, 0,
      0, 0, 0, 3'b111, 3'b000, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b001, T(31,0,0), CV_77,
      3'b111, 3'b000, 0, 0, 0, 0, 0, 0));
    // squash beats issue, dispatch and wakeup
    vt.push_back(mk(1, 3'b111, T(1,2,3), 3'b000, T(31,31,31), 3'b111, 0,
      3'b001, T(31,0,0), CV_77, 3'b111, 3'b000, 0, 16, 0, 0, 0, 0));
    vt.push_back(idle(3'b111, 3'b000, 0, 16, 0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drive(v);
      @(posedge clock);
      #1;
      nm = $sformatf("v%0d", i);
      es = (v.efc > 5'd3) ? 5'd3 : v.efc;
      chk({nm, " is_valid"}, 64'(is_valid), 64'(v.eiv));
      chk({nm, " free_cnt"}, 64'(free_cnt), 64'(v.efc));
      chk({nm, " dp_free_slots"}, 64'(dp_free_slots), 64'(es));
      chk({nm, " dp_overflow"}, 64'(dp_overflow), 64'(v.eovf));
      for (int l = 0; l < 3; l++) begin
        if (v.eiv[l]) begin
          chk($sformatf("%s is_tag[%0d]", nm, l),
              64'(is_tag[l*5 +: 5]), 64'(v.etag[l*5 +: 5]));
        end
      end
      if (v.ck) begin
        chk({nm, " src1[0]"}, 64'(is_src1_val[31:0]), 64'(v.e1));
        chk({nm, " src2[0]"}, 64'(is_src2_val[31:0]), 64'(v.e2));
        chk({nm, " payload[0]"}, is_payload[63:0],
            {32'hC0DE_0000 | 32'(v.etag[4:0]), 32'h1234_5678});
      end
    end

    // build 5 busy entries with is_valid=101, then reset mid-cycle
    drive(mk(0, 3'b111, T(1,2,3), 3'b111, 0, 3'b111, 0, 0, 0, 0,
      3'b000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    chk("rst e1 free_cnt", 64'(free_cnt), 64'd13);
    drive(mk(0, 3'b111, T(20,21,22), 3'b000, T(30,30,30), 3'b111, 0,
      0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    chk("rst e2 is_valid", 64'(is_valid), 64'(3'b111));
    chk("rst e2 free_cnt", 64'(free_cnt), 64'd13);
    drive(mk(0, 3'b011, T(23,24,0), 3'b000, T(30,30,30), 3'b111, 0,
      0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    chk("rst e3 is_valid", 64'(is_valid), 64'(3'b101));
    chk("rst e3 free_cnt", 64'(free_cnt), 64'd11);
    drive(idle(3'b111, 0, 0, 16, 0, 0, 0, 0));
    #3;
    reset = 1'b0;
    #1;
    chk_idle_state("async rst");
    chk("async rst is_tag", 64'(is_tag), 64'd0);
    chk("async rst src1", is_src1_val[63:0], 64'd0);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_idle_state("post rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
